// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: read-side bus of the UART receive FIFO.
// Groups the consumer handshake (r_en, rd_valid, read_data), the occupancy
// flags and count, and the sticky error flags with their clear.
//   master : consumer side (drives r_en, clr_err)
//   slave  : uart_rx_fifo side (drives data, flags, count, errors)
`timescale 1ns/1ps
interface uart_rx_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1024
);
  logic                   r_en;
  logic                   clr_err;
  logic [WIDTH-1:0]       read_data;
  logic                   rd_valid;
  logic                   full;
  logic                   a_full;
  logic                   empty;
  logic                   a_empty;
  logic [$clog2(DEPTH):0] count;
  logic                   frame_err;
  logic                   parity_err;
  logic                   overflow;

  modport master (
    output r_en, clr_err,
    input  read_data, rd_valid, full, a_full, empty, a_empty, count,
           frame_err, parity_err, overflow
  );

  modport slave (
    input  r_en, clr_err,
    output read_data, rd_valid, full, a_full, empty, a_empty, count,
           frame_err, parity_err, overflow
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: parametrised UART receiver feeding a synchronous FIFO.
// A serial frame (start, WIDTH data bits, optional parity, stop) is sampled
// at mid-bit, checked, and written into a DEPTH-word FIFO that a consumer
// drains through a read-enable handshake.
// Ports:
//   clk    in  system clock, rising edge
//   reset  in  asynchronous active-high reset
//   rx     in  serial input, idle high, asynchronous to clk
//   bus    slave modport of uart_rx_fifo_if:
//            r_en/clr_err in; read_data, rd_valid, full, a_full, empty,
//            a_empty, count, frame_err, parity_err, overflow out
`timescale 1ns/1ps
module uart_rx_fifo #(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 1024,
  parameter int LEVEL        = 64,
  parameter int CLKS_PER_BIT = 1,
  parameter int MSB_FIRST    = 1,
  parameter int PARITY       = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rx,
  uart_rx_fifo_if.slave bus
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam int HALF = (CLKS_PER_BIT - 1) / 2;
  localparam int TW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [TW-1:0] TMR_BIT  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TMR_HALF = TW'((HALF > 0) ? HALF - 1 : 0);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // Shift one received bit into the word in the configured bit order.
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] s,
                                                input logic b);
    if (MSB_FIRST != 0) return (s << 1) | WIDTH'(b);
    else                return (s >> 1) | (WIDTH'(b) << (WIDTH - 1));
  endfunction

  // Mode 2: the parity bit must repeat the XOR of the data bits.
  // Mode 1: the parity bit must be the complement of that XOR.
  function automatic logic parity_ok(input logic [WIDTH-1:0] s, input logic p);
    case (PARITY)
      1:       return p == ~(^s);
      2:       return p == (^s);
      default: return 1'b1;
    endcase
  endfunction

  // ---------------------------------------------------------------
  // Stage: rx synchroniser (two flops, idle high)
  // ---------------------------------------------------------------
  logic rx_meta;
  logic rxs;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  // ---------------------------------------------------------------
  // Stage: frame FSM (timing relative to rxs)
  // ---------------------------------------------------------------
  state_t          state, state_next;
  logic [TW-1:0]   tmr, tmr_next;
  logic [BW-1:0]   bit_cnt, bit_next;
  logic            data_take;
  logic            par_take;
  logic            stop_take;
  logic [WIDTH-1:0] shreg;
  logic            par_bit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      tmr     <= '0;
      bit_cnt <= '0;
    end else begin
      state   <= state_next;
      tmr     <= tmr_next;
      bit_cnt <= bit_next;
    end
  end

  always_comb begin
    state_next = state;
    tmr_next   = (tmr == '0) ? '0 : tmr - TW'(1);
    bit_next   = bit_cnt;
    data_take  = 1'b0;
    par_take   = 1'b0;
    stop_take  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!rxs) begin
          // With a one-cycle bit the falling edge itself is mid-start.
          if (HALF == 0) begin
            state_next = S_DATA;
            tmr_next   = TMR_BIT;
            bit_next   = '0;
          end else begin
            state_next = S_START;
            tmr_next   = TMR_HALF;
          end
        end
      end
      S_START: begin
        if (tmr == '0) begin
          if (rxs) begin
            state_next = S_IDLE;   // start bit did not hold to mid-bit
          end else begin
            state_next = S_DATA;
            tmr_next   = TMR_BIT;
            bit_next   = '0;
          end
        end
      end
      S_DATA: begin
        if (tmr == '0) begin
          data_take = 1'b1;
          tmr_next  = TMR_BIT;
          bit_next  = bit_cnt + BW'(1);
          if (bit_cnt == LAST_BIT) state_next = (PARITY != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (tmr == '0) begin
          par_take   = 1'b1;
          tmr_next   = TMR_BIT;
          state_next = S_STOP;
        end
      end
      S_STOP: begin
        if (tmr == '0) begin
          stop_take  = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Word assembly; after WIDTH shifts only data bits remain in shreg.
  always_ff @(posedge clk) begin
    if (data_take) shreg <= shift_in(shreg, rxs);
    if (par_take)  par_bit <= rxs;
  end

  // ---------------------------------------------------------------
  // Stage: frame check -> one-cycle write request
  // ---------------------------------------------------------------
  logic             wr_req;
  logic [WIDTH-1:0] wr_word;
  logic             frame_err_q;
  logic             parity_err_q;
  logic             overflow_q;
  logic             bad_stop;
  logic             bad_par;

  assign bad_stop = stop_take && !rxs;
  assign bad_par  = stop_take && !parity_ok(shreg, par_bit);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) wr_req <= 1'b0;
    else       wr_req <= stop_take && !bad_stop && !bad_par;
  end

  always_ff @(posedge clk) begin
    if (stop_take) wr_word <= shreg;
  end

  // ---------------------------------------------------------------
  // Stage: FIFO storage, pointers, registered flags
  // ---------------------------------------------------------------
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count_q, count_next;
  logic             full_q, a_full_q, empty_q, a_empty_q;
  logic             rd_acc, wr_acc, ovf_set;
  logic [WIDTH-1:0] read_data_q;
  logic             rd_valid_q;

  assign rd_acc  = bus.r_en && !empty_q;
  // A read in the same cycle frees the slot, so a full FIFO still accepts.
  assign wr_acc  = wr_req && (!full_q || rd_acc);
  assign ovf_set = wr_req && full_q && !rd_acc;

  always_comb begin
    count_next = count_q;
    if (wr_acc && !rd_acc)      count_next = count_q + CW'(1);
    else if (rd_acc && !wr_acc) count_next = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= wr_word;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      a_full_q    <= 1'b0;
      empty_q     <= 1'b1;
      a_empty_q   <= 1'b1;
      read_data_q <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) begin
        rd_ptr      <= rd_ptr + AW'(1);
        read_data_q <= mem[rd_ptr];
      end
      rd_valid_q <= rd_acc;
      count_q    <= count_next;
      // Flags come from the next count so they agree with count every cycle.
      full_q     <= (count_next == CW'(DEPTH));
      a_full_q   <= (count_next >= CW'(DEPTH - LEVEL));
      empty_q    <= (count_next == '0);
      a_empty_q  <= (count_next <= CW'(LEVEL));
    end
  end

  // Sticky errors: a new error in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      frame_err_q  <= bad_stop || (frame_err_q  && !bus.clr_err);
      parity_err_q <= bad_par  || (parity_err_q && !bus.clr_err);
      overflow_q   <= ovf_set  || (overflow_q   && !bus.clr_err);
    end
  end

  assign bus.read_data  = read_data_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.full       = full_q;
  assign bus.a_full     = a_full_q;
  assign bus.empty      = empty_q;
  assign bus.a_empty    = a_empty_q;
  assign bus.count      = count_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.parity_err = parity_err_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed bench for uart_rx_fifo.
// dut_a: 8N1, MSB first, one clock per bit, DEPTH 1024, LEVEL 64.
// dut_b: 8 data bits, LSB first, parity mode 2, eight clocks per bit, DEPTH 16.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

  logic clk = 1'b0;
  logic reset;
  logic rx_a;
  logic rx_b;

  always #5 clk = ~clk;

  uart_rx_fifo_if #(.WIDTH(8), .DEPTH(1024)) bus_a ();
  uart_rx_fifo_if #(.WIDTH(8), .DEPTH(16))   bus_b ();

  uart_rx_fifo #(
    .WIDTH(8), .DEPTH(1024), .LEVEL(64), .CLKS_PER_BIT(1), .MSB_FIRST(1), .PARITY(0)
  ) dut_a (
    .clk(clk), .reset(reset), .rx(rx_a), .bus(bus_a)
  );

  uart_rx_fifo #(
    .WIDTH(8), .DEPTH(16), .LEVEL(4), .CLKS_PER_BIT(8), .MSB_FIRST(0), .PARITY(2)
  ) dut_b (
    .clk(clk), .reset(reset), .rx(rx_b), .bus(bus_b)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    logic       clr;
    logic       exp_perr;
    logic       exp_ferr;
    int         exp_count;
  } vec_t;

  vec_t vb [5];
  logic [7:0] q [$];
  logic [7:0] d;
  logic [7:0] last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-clock-per-bit frame, MSB first; leaves rx at the stop level.
  task automatic send_a(input logic [7:0] v, input logic stop);
    rx_a = 1'b0; tick(1);
    for (int i = 7; i >= 0; i--) begin
      rx_a = v[i]; tick(1);
    end
    rx_a = stop; tick(1);
  endtask

  // Eight-clocks-per-bit frame, LSB first, explicit parity bit.
  // A low stop bit is held only past its mid-bit sample so it is not
  // mistaken for the next start bit.
  task automatic send_b(input logic [7:0] v, input logic par, input logic stop);
    rx_b = 1'b0; tick(8);
    for (int i = 0; i < 8; i++) begin
      rx_b = v[i]; tick(8);
    end
    rx_b = par;  tick(8);
    rx_b = stop; tick(stop ? 8 : 4);
    rx_b = 1'b1;
  endtask

  task automatic read_a(input logic [7:0] exp, input string name);
    bus_a.r_en = 1'b1; tick(1); bus_a.r_en = 1'b0;
    check({name, " rd_valid"}, 32'(bus_a.rd_valid), 32'd1);
    check({name, " data"}, 32'(bus_a.read_data), 32'(exp));
  endtask

  task automatic read_b(input logic [7:0] exp, input string name);
    bus_b.r_en = 1'b1; tick(1); bus_b.r_en = 1'b0;
    check({name, " rd_valid"}, 32'(bus_b.rd_valid), 32'd1);
    check({name, " data"}, 32'(bus_b.read_data), 32'(exp));
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //            data   par   stop  clr   perr  ferr  count
    vb[0] = '{8'h01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0};
    vb[1] = '{8'h01, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1};
    vb[2] = '{8'h03, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2};
    vb[3] = '{8'h80, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2};
    vb[4] = '{8'h7F, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3};

    reset = 1'b1; rx_a = 1'b1; rx_b = 1'b1;
    bus_a.r_en = 1'b0; bus_a.clr_err = 1'b0;
    bus_b.r_en = 1'b0; bus_b.clr_err = 1'b0;
    tick(3);

    check("reset count",    32'(bus_a.count),      32'd0);
    check("reset empty",    32'(bus_a.empty),      32'd1);
    check("reset a_empty",  32'(bus_a.a_empty),    32'd1);
    check("reset full",     32'(bus_a.full),       32'd0);
    check("reset a_full",   32'(bus_a.a_full),     32'd0);
    check("reset rd_valid", 32'(bus_a.rd_valid),   32'd0);
    check("reset data",     32'(bus_a.read_data),  32'd0);
    check("reset errors",   32'({bus_a.frame_err, bus_a.parity_err, bus_a.overflow}), 32'd0);
    check("reset b count",  32'(bus_b.count),      32'd0);
    reset = 1'b0;
    tick(2);

    // dut_b: parity / framing vectors
    for (int i = 0; i < 5; i++) begin
      if (vb[i].clr) begin
        bus_b.clr_err = 1'b1; tick(1); bus_b.clr_err = 1'b0;
      end
      send_b(vb[i].data, vb[i].par, vb[i].stop);
      tick(6);
      check($sformatf("vec%0d parity_err", i), 32'(bus_b.parity_err), 32'(vb[i].exp_perr));
      check($sformatf("vec%0d frame_err", i),  32'(bus_b.frame_err),  32'(vb[i].exp_ferr));
      check($sformatf("vec%0d count", i),      32'(bus_b.count),      32'(vb[i].exp_count));
    end

    // dut_b: two-cycle low glitch must not start a frame
    rx_b = 1'b0; tick(2); rx_b = 1'b1; tick(12);
    check("glitch count",  32'(bus_b.count), 32'd3);
    check("glitch errors", 32'({bus_b.frame_err, bus_b.parity_err}), 32'd0);
    send_b(8'h55, 1'b0, 1'b1);
    tick(6);
    check("post-glitch count", 32'(bus_b.count), 32'd4);
    read_b(8'h01, "b rd0");
    read_b(8'h03, "b rd1");
    read_b(8'h7F, "b rd2");
    read_b(8'h55, "b rd3");
    tick(1);
    check("b empty after drain", 32'(bus_b.empty), 32'd1);

    // dut_a: back-to-back frames
    send_a(8'hA5, 1'b1);
    send_a(8'h3C, 1'b1);
    rx_a = 1'b1; tick(6);
    check("b2b count", 32'(bus_a.count), 32'd2);
    read_a(8'hA5, "b2b rd0");
    read_a(8'h3C, "b2b rd1");
    tick(1);
    check("b2b rd_valid one cycle", 32'(bus_a.rd_valid), 32'd0);
    check("b2b empty", 32'(bus_a.empty), 32'd1);

    // dut_a: fill to DEPTH with threshold checks
    for (int i = 1; i <= 1024; i++) begin
      d = 8'($urandom);
      q.push_back(d);
      send_a(d, 1'b1);
      if (i == 64 || i == 65 || i == 959 || i == 960 || i == 1023 || i == 1024) begin
        rx_a = 1'b1; tick(6);
        check($sformatf("fill%0d count", i),   32'(bus_a.count),   32'(i));
        check($sformatf("fill%0d a_empty", i), 32'(bus_a.a_empty), 32'(i <= 64));
        check($sformatf("fill%0d a_full", i),  32'(bus_a.a_full),  32'(i >= 960));
        check($sformatf("fill%0d full", i),    32'(bus_a.full),    32'(i == 1024));
        check($sformatf("fill%0d empty", i),   32'(bus_a.empty),   32'd0);
      end
    end
    check("fill overflow", 32'(bus_a.overflow), 32'd0);

    // one more frame while full is dropped
    send_a(8'hEE, 1'b1);
    rx_a = 1'b1; tick(6);
    check("ovf flag",  32'(bus_a.overflow), 32'd1);
    check("ovf count", 32'(bus_a.count),    32'd1024);
    check("ovf other errors", 32'({bus_a.frame_err, bus_a.parity_err}), 32'd0);

    last = 8'h00;
    for (int i = 0; i < 1024; i++) begin
      last = q.pop_front();
      read_a(last, $sformatf("drain%0d", i));
    end
    tick(1);
    check("drain empty", 32'(bus_a.empty), 32'd1);
    check("drain count", 32'(bus_a.count), 32'd0);

    // read while empty is ignored
    bus_a.r_en = 1'b1; tick(1); bus_a.r_en = 1'b0;
    check("underflow rd_valid", 32'(bus_a.rd_valid),  32'd0);
    check("underflow data",     32'(bus_a.read_data), 32'(last));
    check("underflow count",    32'(bus_a.count),     32'd0);

    bus_a.clr_err = 1'b1; tick(1); bus_a.clr_err = 1'b0;
    check("clr overflow", 32'(bus_a.overflow), 32'd0);

    // reset in the middle of a frame with five words held
    for (int i = 0; i < 5; i++) send_a(8'(8'h10 + i), 1'b1);
    rx_a = 1'b1; tick(6);
    check("pre-reset count", 32'(bus_a.count), 32'd5);
    rx_a = 1'b0; tick(1);
    d = 8'hC3;
    for (int i = 7; i >= 4; i--) begin
      rx_a = d[i]; tick(1);
    end
    rx_a = d[3];
    reset = 1'b1; tick(1);
    check("mid reset count",    32'(bus_a.count),     32'd0);
    check("mid reset empty",    32'(bus_a.empty),     32'd1);
    check("mid reset a_empty",  32'(bus_a.a_empty),   32'd1);
    check("mid reset data",     32'(bus_a.read_data), 32'd0);
    check("mid reset rd_valid", 32'(bus_a.rd_valid),  32'd0);
    rx_a = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(3);
    send_a(8'h5A, 1'b1);
    rx_a = 1'b1; tick(6);
    check("post-reset count", 32'(bus_a.count), 32'd1);
    check("post-reset errors", 32'({bus_a.frame_err, bus_a.parity_err, bus_a.overflow}), 32'd0);
    read_a(8'h5A, "post-reset rd");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
